// File: rtl/pipe_stage_buffer.sv
// Elastic circular-buffer pipeline register carrying DEPTH stage bundles, with flush and optional sticky halt.
// Latency: an entry pushed at edge N is presented on out_* after edge N (1 cycle), read straight from registers.
// Backpressure: in_ready drops when full (or halted); with BYPASS_READY a full buffer still accepts when popping.
module pipe_stage_buffer #(
    parameter int WIDTH        = 128,
    parameter int DEPTH        = 2,
    parameter int BYPASS_READY = 1,
    parameter int HALT_BIT     = -1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       halted
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HSH = (HALT_BIT >= 0) ? HALT_BIT : 0;
    // All-zero mask when the halt feature is disabled, so no negative index is ever formed.
    localparam logic [WIDTH-1:0] HALT_MASK = (HALT_BIT >= 0) ? (WIDTH'(1) << HSH) : '0;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             full;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full = (count == CW'(DEPTH));

    generate
        if (BYPASS_READY != 0) begin : g_bypass
            assign in_ready = !halted && (!full || out_ready);
        end else begin : g_no_bypass
            assign in_ready = !halted && !full;
        end
    endgenerate

    assign out_valid = (count != '0);
    assign out_data  = mem[rptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
            halted <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; only occupancy and pointers are discarded.
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
            halted <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= in_data;
                wptr      <= next_ptr(wptr);
                if (|(in_data & HALT_MASK)) begin
                    halted <= 1'b1;
                end
            end
            if (pop) begin
                rptr <= next_ptr(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Drives three buffer configurations with directed and random traffic against a queue-based reference model.
module tb_pipe_stage_buffer;

    function automatic int dep_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 3;
    endfunction
    function automatic int byp_of(input int k);
        return (k == 0) ? 0 : 1;
    endfunction
    function automatic int hb_of(input int k);
        return (k == 2) ? 0 : -1;
    endfunction

    logic        CLK = 1'b0;
    logic        nRST;
    logic        fl   [3];
    logic        iv   [3];
    logic        ordy [3];
    logic [15:0] idat [3];
    logic [15:0] odat [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        hl   [3];
    logic [1:0]  cnt  [3];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = dep_of(g);
        logic [$clog2(D+1)-1:0] c;
        pipe_stage_buffer #(
            .WIDTH(16), .DEPTH(D), .BYPASS_READY(byp_of(g)), .HALT_BIT(hb_of(g))
        ) u_dut (
            .CLK(CLK), .nRST(nRST), .flush(fl[g]),
            .in_valid(iv[g]), .in_ready(ir[g]), .in_data(idat[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(odat[g]),
            .count(c), .halted(hl[g])
        );
        assign cnt[g] = 2'(c);
    end

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents and the sticky halt flag.
    logic [15:0] q[$];
    bit          mh;

    // Outputs sampled during the most recent cycle, for directed checks.
    logic [1:0]  s_cnt;
    logic        s_ov, s_ir, s_hl;
    logic [15:0] s_dat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input int k, input string tag, input logic f, input logic v,
                         input logic [15:0] d, input logic r);
        int          dp;
        bit          exp_ov, exp_ir, push, pop;
        logic [15:0] mask;
        dp   = dep_of(k);
        mask = (hb_of(k) >= 0) ? (16'(1) << hb_of(k)) : 16'h0;
        @(negedge CLK);
        fl[k] = f; iv[k] = v; idat[k] = d; ordy[k] = r;
        #1;
        s_cnt = cnt[k]; s_ov = ov[k]; s_ir = ir[k]; s_hl = hl[k]; s_dat = odat[k];
        exp_ov = (q.size() != 0);
        exp_ir = !mh && ((q.size() < dp) || (byp_of(k) != 0 && q.size() == dp && r));
        check({tag, ".count"}, s_cnt, q.size());
        check({tag, ".bound"}, 32'(s_cnt <= dp), 1);
        check({tag, ".out_valid"}, s_ov, exp_ov);
        check({tag, ".in_ready"}, s_ir, exp_ir);
        check({tag, ".halted"}, s_hl, mh);
        if (exp_ov) check({tag, ".out_data"}, s_dat, q[0]);
        push = v && exp_ir;
        pop  = exp_ov && r;
        @(posedge CLK);
        if (f) begin
            q.delete();
            mh = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(d);
                if ((d & mask) != 0) mh = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int k, input string tag);
        for (int i = 0; i < 3; i++) begin
            fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0; idat[i] = 16'h0;
        end
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        check({tag, ".rst_count"}, cnt[k], 0);
        check({tag, ".rst_out_valid"}, ov[k], 0);
        check({tag, ".rst_in_ready"}, ir[k], 1);
        check({tag, ".rst_out_data"}, odat[k], 0);
        check({tag, ".rst_halted"}, hl[k], 0);
        @(negedge CLK);
        nRST = 1'b1;
        q.delete();
        mh = 1'b0;
    endtask

    initial begin
        int          pushed;
        logic [15:0] d;
        nRST = 1'b1;
        do_reset(0, "init");

        // Full buffer without bypass: order and ready timing.
        cycle(0, "t2_a", 0, 1, 16'hAAAA, 0);
        cycle(0, "t2_b", 0, 1, 16'hBBBB, 0);
        cycle(0, "t2_full", 0, 1, 16'hCCCC, 0);
        check("t2.full_count", s_cnt, 2);
        check("t2.full_in_ready", s_ir, 0);
        cycle(0, "t2_pop1", 0, 1, 16'hCCCC, 1);
        check("t2.pop1_data", s_dat, 16'hAAAA);
        check("t2.pop1_in_ready", s_ir, 0);
        cycle(0, "t2_pop2", 0, 0, 16'h0, 1);
        check("t2.pop2_data", s_dat, 16'hBBBB);
        check("t2.pop2_in_ready", s_ir, 1);
        cycle(0, "t2_empty", 0, 0, 16'h0, 1);
        check("t2.empty_out_valid", s_ov, 0);

        // Asynchronous reset with two entries held.
        cycle(0, "t1_a", 0, 1, 16'h1111, 0);
        cycle(0, "t1_b", 0, 1, 16'h2222, 0);
        do_reset(0, "t1");
        cycle(0, "t1_after", 0, 0, 16'h0, 0);
        check("t1.after_count", s_cnt, 0);
        check("t1.after_out_valid", s_ov, 0);
        check("t1.after_in_ready", s_ir, 1);
        check("t1.after_out_data", s_dat, 0);

        // Single entry with bypass streams one per cycle.
        do_reset(1, "t3");
        for (int j = 1; j <= 8; j++) begin
            cycle(1, "t3", 0, 1, 16'(j), 1);
            if (j > 1) begin
                check("t3.stream_data", s_dat, 16'(j - 1));
                check("t3.stream_count", s_cnt, 1);
                check("t3.stream_in_ready", s_ir, 1);
            end
        end
        cycle(1, "t3_last", 0, 0, 16'h0, 1);
        check("t3.last_data", s_dat, 16'd8);

        // Depth-3 wrap with random pops.
        do_reset(2, "t4");
        pushed = 0;
        for (int n = 0; n < 200 && pushed < 10; n++) begin
            d = 16'((pushed + 1) << 1);
            cycle(2, "t4", 0, 1, d, 1'($urandom_range(0, 1)));
            if (s_ir) pushed++;
        end
        check("t4.pushed", pushed, 10);
        for (int n = 0; n < 4; n++) cycle(2, "t4_drain", 0, 0, 16'h0, 1);
        check("t4.drained_count", s_cnt, 0);

        // Flush beats a same-cycle push and pop.
        do_reset(2, "t5");
        cycle(2, "t5_a", 0, 1, 16'h0010, 0);
        cycle(2, "t5_b", 0, 1, 16'h0020, 0);
        cycle(2, "t5_flush", 1, 1, 16'h0030, 1);
        check("t5.pre_count", s_cnt, 2);
        check("t5.flush_in_ready", s_ir, 1);
        for (int n = 0; n < 3; n++) begin
            cycle(2, "t5_post", 0, 0, 16'h0, 1);
            check("t5.post_count", s_cnt, 0);
            check("t5.post_out_valid", s_ov, 0);
        end

        // Sticky halt on bit 0, drain, then flush clears it.
        do_reset(2, "t6");
        cycle(2, "t6_a", 0, 1, 16'h0002, 0);
        cycle(2, "t6_b", 0, 1, 16'h0001, 0);
        cycle(2, "t6_halt", 0, 1, 16'h0004, 1);
        check("t6.halted", s_hl, 1);
        check("t6.halt_in_ready", s_ir, 0);
        check("t6.drain1", s_dat, 16'h0002);
        cycle(2, "t6_drain", 0, 0, 16'h0, 1);
        check("t6.drain2", s_dat, 16'h0001);
        check("t6.still_halted", s_hl, 1);
        cycle(2, "t6_flush", 1, 0, 16'h0, 0);
        cycle(2, "t6_clear", 0, 0, 16'h0, 0);
        check("t6.clear_halted", s_hl, 0);
        check("t6.clear_in_ready", s_ir, 1);

        // Random traffic on every configuration.
        for (int k = 0; k < 3; k++) begin
            do_reset(k, "rnd");
            for (int n = 0; n < 400; n++) begin
                d = 16'($urandom) & 16'hFFFE;
                d[0] = ($urandom_range(0, 15) == 0);
                cycle(k, "rnd", 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) < 7),
                      d, 1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
